// File: rtl/spi_ws2812_bridge_if.sv
// Pin bundle between the MSS SPI_0 master side and the WS2812 bridge:
// SPI lines in, LED data line and status flags out.
`timescale 1ns/1ps
interface spi_ws2812_bridge_if;
  logic SPI_SCK;
  logic SPI_SS_N;
  logic SPI_MOSI;
  logic LED_DOUT;
  logic BUSY;
  logic FIFO_OVF;

  modport master (
    output SPI_SCK, SPI_SS_N, SPI_MOSI,
    input  LED_DOUT, BUSY, FIFO_OVF
  );

  modport slave (
    input  SPI_SCK, SPI_SS_N, SPI_MOSI,
    output LED_DOUT, BUSY, FIFO_OVF
  );
endinterface

// File: rtl/spi_ws2812_bridge.sv
// Write-only SPI slave (mode 0, MSB first) feeding a byte FIFO that is
// re-serialised as WS2812 NRZ bits; an empty FIFO ends the frame with a latch low.
`timescale 1ns/1ps
module spi_ws2812_bridge #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned BIT_CYC   = 25,
  parameter int unsigned T0H_CYC   = 8,
  parameter int unsigned T1H_CYC   = 16,
  parameter int unsigned LATCH_CYC = 1200
) (
  input logic                 CLK,
  input logic                 RESET,
  spi_ws2812_bridge_if.slave  bus
);

  localparam int unsigned DEPTH   = 2 ** FIFO_AW;
  localparam int unsigned CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  typedef logic [CW-1:0]      cnt_t;
  typedef logic [FIFO_AW:0]   ptr_t;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  localparam cnt_t BIT_LAST   = cnt_t'(BIT_CYC - 1);
  localparam cnt_t T0H_LAST   = cnt_t'(T0H_CYC - 1);
  localparam cnt_t T1H_LAST   = cnt_t'(T1H_CYC - 1);
  localparam cnt_t LATCH_LAST = cnt_t'(LATCH_CYC - 1);

  // SPI receive path
  logic       sck_meta_q, sck_sync_q, sck_prev_q;
  logic       ss_meta_q, ss_sync_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_shreg_q, rx_shreg_d;
  logic       push_q, push_d;
  logic [7:0] push_data_q, push_data_d;
  logic       sck_rise;

  // FIFO
  logic [7:0] mem_q [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic       ovf_q, ovf_d;
  logic       full, empty, push_ok, pop;
  logic [7:0] rd_data;

  // Serialiser
  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       led_q, led_d;
  logic       busy_q, busy_d;
  cnt_t       th_last;

  always_comb begin
    sck_rise    = sck_sync_q & ~sck_prev_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shreg_d  = rx_shreg_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (ss_sync_q) begin
      rx_cnt_d = '0;
    end else if (sck_rise) begin
      rx_shreg_d = {rx_shreg_q[6:0], mosi_sync_q};
      rx_cnt_d   = rx_cnt_q + 3'd1;
      if (rx_cnt_q == 3'd7) begin
        push_d      = 1'b1;
        push_data_d = {rx_shreg_q[6:0], mosi_sync_q};
      end
    end
  end

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
              (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    rd_data = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    push_ok  = push_q && (!full || pop);
    wr_ptr_d = wr_ptr_q + ptr_t'(push_ok);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    ovf_d    = ovf_q | (push_q & ~push_ok);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    led_d     = led_q;
    pop       = 1'b0;
    th_last   = shreg_q[7] ? T1H_LAST : T0H_LAST;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        led_d = 1'b0;
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = rd_data;
          bit_idx_d = 3'd7;
          state_d   = HIGH;
          led_d     = 1'b1;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == th_last) begin
          state_d = LOW;
          led_d   = 1'b0;
        end
      end
      LOW: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q != 3'd0) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q - 3'd1;
            state_d   = HIGH;
            led_d     = 1'b1;
          end else if (!empty) begin
            pop       = 1'b1;
            shreg_d   = rd_data;
            bit_idx_d = 3'd7;
            state_d   = HIGH;
            led_d     = 1'b1;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_shreg_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_meta_q  <= bus.SPI_SCK;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ss_meta_q   <= bus.SPI_SS_N;
      ss_sync_q   <= ss_meta_q;
      mosi_meta_q <= bus.SPI_MOSI;
      mosi_sync_q <= mosi_meta_q;
      rx_cnt_q    <= rx_cnt_d;
      rx_shreg_q  <= rx_shreg_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.LED_DOUT = led_q;
  assign bus.BUSY     = busy_q;
  assign bus.FIFO_OVF = ovf_q;

endmodule

// File: tb/tb_spi_ws2812_bridge.sv
// Bench for spi_ws2812_bridge: drives SPI bytes, measures LED pulse widths,
// bit periods, latch length and status flags against hand-derived values.
`timescale 1ns/1ps
module tb_spi_ws2812_bridge;
  logic CLK = 1'b0;
  logic RESET;

  spi_ws2812_bridge_if bus ();

  spi_ws2812_bridge #(
    .FIFO_AW(4), .BIT_CYC(25), .T0H_CYC(8), .T1H_CYC(16), .LATCH_CYC(1200)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #25 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // LED / BUSY edge recorder, sampled on the falling clock edge
  int   rises[$];
  int   highs[$];
  int   falls[$];
  logic led_prev  = 1'b0;
  logic busy_prev = 1'b0;
  int   run = 0;
  always @(negedge CLK) begin
    if (bus.LED_DOUT && !led_prev) begin
      rises.push_back(cyc);
      run = 1;
    end else if (bus.LED_DOUT) begin
      run++;
    end else if (led_prev) begin
      highs.push_back(run);
    end
    if (!bus.BUSY && busy_prev) falls.push_back(cyc);
    led_prev  = bus.LED_DOUT;
    busy_prev = bus.BUSY;
  end

  int checks = 0;
  int errors = 0;
  int last_sck_cyc = 0;
  int exp_w [0:199];

  typedef struct {
    string      name;
    logic [7:0] din;
    int         pre_bits;
    int         exp_high [8];
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ss_low(input int half);
    @(posedge CLK);
    #10;
    bus.SPI_SS_N = 1'b0;
    #(half);
  endtask

  task automatic ss_high(input int half);
    #(half);
    bus.SPI_SS_N = 1'b1;
    repeat (5) @(posedge CLK);
  endtask

  task automatic spi_xfer(input logic [7:0] b, input int nbits, input int half);
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.SPI_MOSI = b[i];
      #(half);
      bus.SPI_SCK  = 1'b1;
      last_sck_cyc = cyc;
      #(half);
      bus.SPI_SCK  = 1'b0;
    end
  endtask

  task automatic wait_fall(input int fb, input int limit, input string nm);
    int n = 0;
    while (falls.size() <= fb && n < limit) begin
      @(negedge CLK);
      #2;
      n++;
    end
    chk({nm, " frame_end_seen"}, int'(falls.size() > fb), 1);
  endtask

  task automatic check_frame(input string nm, input int rb, input int hb,
                             input int fb, input int nb);
    wait_fall(fb, nb * 25 + 1200 + 500, nm);
    chk({nm, " rise_count"}, rises.size() - rb, nb);
    chk({nm, " high_count"}, highs.size() - hb, nb);
    if (rises.size() - rb == nb && highs.size() - hb == nb && falls.size() > fb) begin
      for (int k = 0; k < nb; k++) begin
        chk($sformatf("%s bit%0d_high", nm, k), highs[hb + k], exp_w[k]);
        if (k > 0)
          chk($sformatf("%s bit%0d_period", nm, k), rises[rb + k] - rises[rb + k - 1], 25);
      end
      chk({nm, " busy_fall"}, falls[fb] - rises[rb], nb * 25 + 1200);
    end
  endtask

  task automatic do_reset_check(input string nm);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk({nm, " led_in_reset"},  int'(bus.LED_DOUT), 0);
    chk({nm, " busy_in_reset"}, int'(bus.BUSY), 0);
    chk({nm, " ovf_in_reset"},  int'(bus.FIFO_OVF), 0);
    RESET = 1'b0;
    repeat (100) @(negedge CLK);
    chk({nm, " led_after"},  int'(bus.LED_DOUT), 0);
    chk({nm, " busy_after"}, int'(bus.BUSY), 0);
    chk({nm, " ovf_after"},  int'(bus.FIFO_OVF), 0);
  endtask

  initial begin
    int rb, hb, fb, nb, n, rn;
    logic [7:0] b2b [3];
    logic [7:0] byt, prev_byt;
    int ok_w;

    vecs[0] = '{"a5",          8'hA5, 0, '{16, 8, 16, 8, 8, 16, 8, 16}};
    vecs[1] = '{"partial_3c",  8'h3C, 5, '{8, 8, 16, 16, 16, 16, 8, 8}};
    vecs[2] = '{"x01",         8'h01, 0, '{8, 8, 8, 8, 8, 8, 8, 16}};
    vecs[3] = '{"partial_f0",  8'hF0, 3, '{16, 16, 16, 16, 8, 8, 8, 8}};

    bus.SPI_SCK  = 1'b0;
    bus.SPI_SS_N = 1'b1;
    bus.SPI_MOSI = 1'b0;
    RESET        = 1'b0;
    #3;
    do_reset_check("reset");

    // Single-byte frames, some preceded by an aborted partial byte
    for (int v = 0; v < 4; v++) begin
      rb = rises.size(); hb = highs.size(); fb = falls.size();
      if (vecs[v].pre_bits > 0) begin
        ss_low(250);
        spi_xfer(8'hFF, vecs[v].pre_bits, 250);
        ss_high(250);
      end
      ss_low(250);
      spi_xfer(vecs[v].din, 8, 250);
      ss_high(250);
      for (int k = 0; k < 8; k++) exp_w[k] = vecs[v].exp_high[k];
      check_frame(vecs[v].name, rb, hb, fb, 8);
      if (rises.size() > rb)
        chk({vecs[v].name, " latency"}, rises[rb] - last_sck_cyc, 5);
    end

    // Three bytes in one SS window: continuous 24-bit stream
    b2b[0] = 8'hFF; b2b[1] = 8'h00; b2b[2] = 8'h80;
    for (int k = 0; k < 24; k++) exp_w[k] = 8;
    for (int k = 0; k < 8; k++) exp_w[k] = 16;
    exp_w[16] = 16;
    rb = rises.size(); hb = highs.size(); fb = falls.size();
    ss_low(250);
    for (int i = 0; i < 3; i++) spi_xfer(b2b[i], 8, 250);
    ss_high(250);
    check_frame("b2b", rb, hb, fb, 24);

    // Overflow: 40 bytes at SCK 5 MHz
    rb = rises.size(); hb = highs.size(); fb = falls.size();
    ss_low(100);
    for (int i = 0; i < 40; i++) spi_xfer(8'(i), 8, 100);
    ss_high(100);
    chk("ovf_flag_set", int'(bus.FIFO_OVF), 1);
    wait_fall(fb, 12000, "ovf");
    nb = highs.size() - hb;
    chk("ovf bits_multiple_of_8", nb % 8, 0);
    chk("ovf enough_bytes", int'(nb / 8 >= 17), 1);
    chk("ovf one_frame", falls.size() - fb, 1);
    prev_byt = 8'h00;
    for (int i = 0; i < nb / 8; i++) begin
      ok_w = 1;
      byt  = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (highs[hb + i * 8 + k] != 8 && highs[hb + i * 8 + k] != 16) ok_w = 0;
        byt = {byt[6:0], highs[hb + i * 8 + k] == 16};
      end
      chk($sformatf("ovf byte%0d_widths_valid", i), ok_w, 1);
      chk($sformatf("ovf byte%0d_in_range", i), int'(byt < 8'd40), 1);
      if (i == 0) chk("ovf first_byte", int'(byt), 0);
      else chk($sformatf("ovf byte%0d_increasing", i), int'(byt > prev_byt), 1);
      prev_byt = byt;
    end
    for (int k = 1; k < rises.size() - rb; k++)
      if (rises[rb + k] - rises[rb + k - 1] != 25)
        chk($sformatf("ovf period%0d", k), rises[rb + k] - rises[rb + k - 1], 25);
    repeat (300) @(negedge CLK);
    chk("ovf_sticky", int'(bus.FIFO_OVF), 1);
    do_reset_check("ovf_clear");

    // Reset mid-HIGH of bit_idx 3 of the second byte with five bytes queued
    rb = rises.size();
    ss_low(100);
    for (int i = 0; i < 7; i++) spi_xfer(8'hC3 ^ 8'(i), 8, 100);
    ss_high(100);
    n = 0;
    while (rises.size() < rb + 13 && n < 2000) begin
      @(negedge CLK);
      #2;
      n++;
    end
    chk("midreset reached_bit", int'(rises.size() >= rb + 13), 1);
    chk("midreset led_high_before", int'(bus.LED_DOUT), 1);
    #3;
    RESET = 1'b1;
    #1;
    chk("midreset led_async_low", int'(bus.LED_DOUT), 0);
    chk("midreset busy_async_low", int'(bus.BUSY), 0);
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    rn = rises.size();
    repeat (600) @(negedge CLK);
    chk("midreset no_more_pulses", rises.size() - rn, 0);
    chk("midreset busy_idle", int'(bus.BUSY), 0);
    chk("midreset led_low", int'(bus.LED_DOUT), 0);
    chk("midreset ovf_clear", int'(bus.FIFO_OVF), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
